// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin arbiter that serialises four requesters onto a
// single SPI master. Each grant runs one transaction (start pulse, wait for the
// receive strobe or a timeout), returns a one-cycle ack with the response, and
// then inserts a one-cycle slave-select guard gap before the next grant.
module spi_txn_arbiter #(
   parameter int unsigned bits_size = 8,
   parameter int unsigned TIMEOUT   = 1023
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [3:0]             req,
   input  logic [7:0]             req_slave,
   input  logic [4*bits_size-1:0] req_data,
   output logic [3:0]             ack,
   output logic [bits_size-1:0]   rsp_data,
   output logic                   rsp_err,
   output logic                   m_tx_start,
   output logic [bits_size-1:0]   m_data_in,
   output logic [1:0]             slave_sel,
   input  logic                   m_rx_done,
   input  logic [bits_size-1:0]   m_data_out,
   output logic                   busy
);

   // WAIT counter runs 0 .. TIMEOUT-1, so clog2(TIMEOUT) bits are enough
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_RESP  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   logic [2:0]           r_state;
   logic [2:0]           w_state_next;

   logic [1:0]           r_last;       // last served requester (round-robin pointer)
   logic [1:0]           r_idx;        // requester owning the current transaction
   logic [CNT_W-1:0]     r_cnt;        // cycles spent in WAIT
   logic [3:0]           r_ack;
   logic [bits_size-1:0] r_rsp_data;
   logic                 r_rsp_err;
   logic                 r_tx_start;
   logic [bits_size-1:0] r_data_in;
   logic [1:0]           r_slave_sel;
   logic                 r_busy;

   logic                 w_any;
   logic                 w_found;
   logic [1:0]           w_cand;
   logic [1:0]           w_win;
   logic [bits_size-1:0] w_win_data;
   logic [1:0]           w_win_slave;
   logic                 w_expire;
   logic                 w_done;

   assign w_any       = |req;
   assign w_win_data  = req_data[int'(w_win)*bits_size +: bits_size];
   assign w_win_slave = req_slave[{w_win, 1'b0} +: 2];
   assign w_expire    = (r_cnt == CNT_W'(TIMEOUT - 1));
   // receive strobe only matters while a transfer is outstanding
   assign w_done      = (r_state == S_WAIT) && m_rx_done;

   // Round-robin pick: scan from the requester after the last one served
   always_comb begin
      w_win   = 2'd0;
      w_found = 1'b0;
      w_cand  = 2'd0;
      for (int unsigned k = 1; k <= 4; k++) begin
         w_cand = r_last + 2'(k);
         if (!w_found && req[w_cand]) begin
            w_win   = w_cand;
            w_found = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_next = S_START;
            end
         end
         S_START: begin
            w_state_next = S_WAIT;
         end
         S_WAIT: begin
            if (w_done || w_expire) begin
               w_state_next = S_RESP;
            end
         end
         S_RESP: begin
            w_state_next = S_GAP;
         end
         S_GAP: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Grant capture, master-side drive and round-robin pointer update
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last      <= 2'd3;
         r_idx       <= 2'd0;
         r_cnt       <= '0;
         r_tx_start  <= 1'b0;
         r_data_in   <= '0;
         r_slave_sel <= 2'd0;
         r_busy      <= 1'b0;
      end else begin
         r_tx_start <= (w_state_next == S_START);
         r_busy     <= (w_state_next != S_IDLE);
         // latched values stay put until the next grant, covering START..RESP
         if ((r_state == S_IDLE) && w_any) begin
            r_idx       <= w_win;
            r_data_in   <= w_win_data;
            r_slave_sel <= w_win_slave;
         end
         if (r_state == S_START) begin
            r_cnt <= '0;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (r_state == S_RESP) begin
            r_last <= r_idx;
         end
      end
   end

   // Response outputs: nonzero only for the single RESP cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ack      <= 4'd0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
      end else begin
         r_ack      <= 4'd0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
         if ((r_state == S_WAIT) && (w_state_next == S_RESP)) begin
            r_ack <= 4'(4'b0001 << r_idx);
            if (w_done) begin
               r_rsp_data <= m_data_out;
               r_rsp_err  <= 1'b0;
            end else begin
               r_rsp_data <= '0;
               r_rsp_err  <= 1'b1;
            end
         end
      end
   end

   assign ack        = r_ack;
   assign rsp_data   = r_rsp_data;
   assign rsp_err    = r_rsp_err;
   assign m_tx_start = r_tx_start;
   assign m_data_in  = r_data_in;
   assign slave_sel  = r_slave_sel;
   assign busy       = r_busy;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Testbench for spi_txn_arbiter: directed transactions against an SPI master
// model; expected starts and responses are queued and checked by a monitor.
module tb_spi_txn_arbiter;

   localparam int unsigned BW = 8;
   localparam int unsigned TO = 1023;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [3:0]    req;
   logic [7:0]    req_slave;
   logic [4*BW-1:0] req_data;
   logic [3:0]    ack;
   logic [BW-1:0] rsp_data;
   logic          rsp_err;
   logic          m_tx_start;
   logic [BW-1:0] m_data_in;
   logic [1:0]    slave_sel;
   logic          m_rx_done;
   logic [BW-1:0] m_data_out;
   logic          busy;

   logic          r_mst_done;
   logic          r_spur_done;
   logic          mst_en;
   int            mst_delay;
   logic [BW-1:0] mst_key;

   typedef struct packed {
      logic [3:0]    ack;
      logic [BW-1:0] data;
      logic          err;
   } rsp_t;

   typedef struct packed {
      logic [1:0]    slv;
      logic [BW-1:0] data;
   } st_t;

   rsp_t rsp_q[$];
   st_t  st_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   int n_ack   = 0;

   always #5 clk = ~clk;

   assign m_rx_done = r_mst_done | r_spur_done;

   spi_txn_arbiter #(.bits_size(BW), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (req),
      .req_slave  (req_slave),
      .req_data   (req_data),
      .ack        (ack),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .m_tx_start (m_tx_start),
      .m_data_in  (m_data_in),
      .slave_sel  (slave_sel),
      .m_rx_done  (m_rx_done),
      .m_data_out (m_data_out),
      .busy       (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // SPI master model: answers each start with data_in ^ key after mst_delay cycles
   initial begin
      r_mst_done = 1'b0;
      m_data_out = '0;
      forever begin
         @(negedge clk);
         if (reset_n && m_tx_start && mst_en) begin
            repeat (mst_delay) @(negedge clk);
            m_data_out = m_data_in ^ mst_key;
            r_mst_done = 1'b1;
            @(negedge clk);
            r_mst_done = 1'b0;
            m_data_out = '0;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT starts a transfer or acks
   always @(negedge clk) begin
      rsp_t er;
      st_t  es;
      if (reset_n) begin
         if (ack != 4'd0) begin
            n_ack++;
            if (rsp_q.size() == 0) begin
               check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
               er = rsp_q.pop_front();
               check("ack", 32'(ack), 32'(er.ack));
               check("rsp_data", 32'(rsp_data), 32'(er.data));
               check("rsp_err", 32'(rsp_err), 32'(er.err));
            end
         end else if ((rsp_data != '0) || rsp_err) begin
            check("rsp_idle_zero", {23'd0, rsp_err, rsp_data}, 32'd0);
         end
         if (m_tx_start) begin
            if (st_q.size() == 0) begin
               check("unexpected_start", 32'(m_tx_start), 32'd0);
            end else begin
               es = st_q.pop_front();
               check("slave_sel", 32'(slave_sel), 32'(es.slv));
               check("m_data_in", 32'(m_data_in), 32'(es.data));
            end
         end
      end
   end

   task automatic wait_start(input int bound);
      int cyc = 0;
      while (!m_tx_start && cyc < bound) begin
         @(negedge clk);
         cyc++;
      end
      check("start_wait", 32'(m_tx_start), 32'd1);
   endtask

   task automatic wait_ack(input int bound, output int cyc);
      cyc = 0;
      while ((ack == 4'd0) && cyc < bound) begin
         @(negedge clk);
         cyc++;
      end
      check("ack_wait", 32'(ack != 4'd0), 32'd1);
   endtask

   task automatic push_txn(input logic [1:0] slv, input logic [BW-1:0] d,
                           input logic [3:0] a, input logic [BW-1:0] r, input logic e);
      st_q.push_back('{slv: slv, data: d});
      rsp_q.push_back('{ack: a, data: r, err: e});
   endtask

   initial begin
      int cyc;
      int got;
      int base;
      reset_n     = 1'b0;
      req         = 4'd0;
      req_slave   = 8'd0;
      req_data    = '0;
      r_spur_done = 1'b0;
      mst_en      = 1'b0;
      mst_delay   = 1;
      mst_key     = '0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tx_start", 32'(m_tx_start), 32'd0);
      check("rst_data_in", 32'(m_data_in), 32'd0);
      check("rst_slave_sel", 32'(slave_sel), 32'd0);
      check("rst_rsp", {23'd0, rsp_err, rsp_data}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // single request: req[2], slave 1, data A5, master answers 3C after 20 cycles
      mst_en = 1'b1; mst_delay = 20; mst_key = 8'h99;
      req_slave = 8'h10;
      req_data  = 32'h00A5_0000;
      push_txn(2'd1, 8'hA5, 4'b0100, 8'h3C, 1'b0);
      req = 4'b0100;
      @(negedge clk);
      check("t1_tx_start", 32'(m_tx_start), 32'd1);
      check("t1_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("t1_start_once", 32'(m_tx_start), 32'd0);
      wait_ack(100, cyc);
      req = 4'd0;
      repeat (4) @(negedge clk);

      // round robin from reset with all four held: 0,1,2,3,0
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      mst_delay = 3; mst_key = 8'h5A;
      req_slave = 8'hE4;
      req_data  = 32'h1312_1110;
      push_txn(2'd0, 8'h10, 4'b0001, 8'h4A, 1'b0);
      push_txn(2'd1, 8'h11, 4'b0010, 8'h4B, 1'b0);
      push_txn(2'd2, 8'h12, 4'b0100, 8'h48, 1'b0);
      push_txn(2'd3, 8'h13, 4'b1000, 8'h49, 1'b0);
      push_txn(2'd0, 8'h10, 4'b0001, 8'h4A, 1'b0);
      req = 4'b1111;
      got = 0; cyc = 0;
      while (got < 5 && cyc < 600) begin
         @(negedge clk);
         cyc++;
         if (ack != 4'd0) got++;
      end
      req = 4'd0;
      check("rr_acks", 32'(got), 32'd5);
      repeat (4) @(negedge clk);

      // spurious receive strobe in IDLE is ignored
      r_spur_done = 1'b1;
      @(negedge clk);
      r_spur_done = 1'b0;
      check("idle_spur_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("idle_spur_ack", 32'(ack), 32'd0);

      // req[0] dropped during WAIT still completes; strobe during GAP ignored
      base = n_ack;
      mst_delay = 10; mst_key = 8'h0F;
      req_slave = 8'h02;
      req_data  = 32'h0000_0077;
      push_txn(2'd2, 8'h77, 4'b0001, 8'h78, 1'b0);
      req = 4'b0001;
      wait_start(20);
      repeat (3) @(negedge clk);
      req = 4'd0;
      check("drop_busy", 32'(busy), 32'd1);
      wait_ack(50, cyc);
      @(negedge clk);
      r_spur_done = 1'b1;
      @(negedge clk);
      r_spur_done = 1'b0;
      check("gap_spur_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      check("gap_spur_state", {28'd0, busy, m_tx_start, 2'd0}, 32'd0);
      check("drop_single_ack", 32'(n_ack - base), 32'd1);

      // timeout: no receive strobe, ack 1023 cycles after WAIT entry
      mst_en = 1'b0;
      req_slave = 8'h80;
      req_data  = 32'hE700_0000;
      push_txn(2'd2, 8'hE7, 4'b1000, 8'h00, 1'b1);
      req = 4'b1000;
      wait_start(20);
      wait_ack(1200, cyc);
      req = 4'd0;
      check("timeout_latency", 32'(cyc), 32'd1024);
      repeat (3) @(negedge clk);

      // next request after a timeout is served normally
      mst_en = 1'b1; mst_delay = 2; mst_key = 8'hFF;
      req_slave = 8'h00;
      req_data  = 32'h0000_0001;
      push_txn(2'd0, 8'h01, 4'b0001, 8'hFE, 1'b0);
      req = 4'b0001;
      wait_ack(50, cyc);
      req = 4'd0;
      repeat (4) @(negedge clk);

      // reset during WAIT abandons the transfer; req[1] re-arbitrates afterwards
      mst_en = 1'b0;
      req_slave = 8'h0C;
      req_data  = 32'h0000_C300;
      st_q.push_back('{slv: 2'd3, data: 8'hC3});
      req = 4'b0010;
      wait_start(20);
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("wrst_ack", 32'(ack), 32'd0);
      check("wrst_busy", 32'(busy), 32'd0);
      check("wrst_master", {22'd0, m_tx_start, slave_sel, m_data_in}, 32'd0);
      check("wrst_rsp", {23'd0, rsp_err, rsp_data}, 32'd0);
      mst_en = 1'b1; mst_delay = 4; mst_key = 8'h01;
      push_txn(2'd3, 8'hC3, 4'b0010, 8'hC2, 1'b0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      check("wrst_release_idle", 32'(m_tx_start), 32'd0);
      @(negedge clk);
      check("wrst_restart", 32'(m_tx_start), 32'd1);
      wait_ack(50, cyc);
      req = 4'd0;
      repeat (6) @(negedge clk);

      check("sb_rsp_empty", 32'(rsp_q.size()), 32'd0);
      check("sb_start_empty", 32'(st_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
